// File: rtl/rx_frame_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_assembler_if
//  Description : Bundles the receive-side byte stream and the frame readout
//                port of rx_frame_assembler.
//                master : byte source / frame consumer (drives strobes, pops)
//                slave  : the assembler itself
//  Ports       : frame_start, new_data, data_in[7:0], rd_en      (to slave)
//                frame_valid, frame_len[5:0], rd_data[7:0],
//                rd_last, err, err_cnt[7:0]                      (from slave)
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_frame_assembler_if;
  logic       frame_start;
  logic       new_data;
  logic [7:0] data_in;
  logic       rd_en;
  logic       frame_valid;
  logic [5:0] frame_len;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output frame_start, new_data, data_in, rd_en,
    input  frame_valid, frame_len, rd_data, rd_last, err, err_cnt
  );

  modport slave (
    input  frame_start, new_data, data_in, rd_en,
    output frame_valid, frame_len, rd_data, rd_last, err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_assembler
//  Description : Collects SPI receive bytes into a length-prefixed,
//                checksum-protected frame, holds an accepted frame and
//                presents it first-word-fall-through for byte-wise readout.
//                Frame on the wire: N, payload[0..N-1], sum(payload) mod 256.
//  Ports       : clk          system clock
//                rst          asynchronous reset, active low
//                bus (slave)  byte input strobes, readout port, error status
//  Parameters  : MAX_LEN      largest accepted payload length (1..63)
//  Revision    : 1.0  initial release
// ============================================================================
module rx_frame_assembler #(
  parameter int MAX_LEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_frame_assembler_if.slave  bus
);

  localparam int        AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_READY   = 3'd4,
    ST_DROP    = 3'd5
  } state_t;

  state_t     state_q,       state_d;
  logic [5:0] len_q,         len_d;
  logic [5:0] wr_ptr_q,      wr_ptr_d;
  logic [5:0] rd_ptr_q,      rd_ptr_d;
  logic [7:0] sum_q,         sum_d;
  logic       frame_valid_q, frame_valid_d;
  logic [5:0] frame_len_q,   frame_len_d;
  logic       rd_last_q,     rd_last_d;
  logic       err_q,         err_d;
  logic [7:0] err_cnt_q,     err_cnt_d;

  logic       w_wr_en;
  logic       w_len_ok;

  // Payload storage; contents are don't-care until written, so no reset.
  logic [7:0] buffer_mem [MAX_LEN];

  assign w_len_ok = (bus.data_in != 8'd0) && (bus.data_in <= MAX_LEN_B);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    sum_d         = sum_q;
    frame_valid_d = frame_valid_q;
    frame_len_d   = frame_len_q;
    rd_last_d     = rd_last_q;
    err_d         = 1'b0;
    w_wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_d  = ST_LEN;
          wr_ptr_d = 6'd0;
          sum_d    = 8'd0;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        // A new burst while a frame is in flight aborts it; any byte that
        // arrives in the same cycle belongs to neither frame and is dropped.
        if (bus.frame_start) begin
          err_d    = 1'b1;
          state_d  = ST_LEN;
          len_d    = 6'd0;
          wr_ptr_d = 6'd0;
          sum_d    = 8'd0;
        end else if (bus.new_data) begin
          if (state_q == ST_LEN) begin
            if (w_len_ok) begin
              len_d    = bus.data_in[5:0];
              wr_ptr_d = 6'd0;
              sum_d    = 8'd0;
              state_d  = ST_PAYLOAD;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end
          end else if (state_q == ST_PAYLOAD) begin
            w_wr_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + 6'd1;
            sum_d    = sum_q + bus.data_in;
            if (wr_ptr_q == len_q - 6'd1) begin
              state_d = ST_CSUM;
            end
          end else begin
            if (bus.data_in == sum_q) begin
              state_d       = ST_READY;
              frame_valid_d = 1'b1;
              frame_len_d   = len_q;
              rd_ptr_d      = 6'd0;
              rd_last_d     = (len_q == 6'd1);
            end else begin
              err_d   = 1'b1;
              state_d = ST_DROP;
            end
          end
        end
      end

      ST_READY: begin
        // The held frame is never overwritten: bytes arriving now are lost
        // and flagged, and a new burst start is simply not seen.
        if (bus.new_data) begin
          err_d = 1'b1;
        end
        if (bus.rd_en) begin
          if (rd_last_q) begin
            state_d       = ST_IDLE;
            frame_valid_d = 1'b0;
            frame_len_d   = 6'd0;
            rd_ptr_d      = 6'd0;
            rd_last_d     = 1'b0;
          end else begin
            rd_ptr_d  = rd_ptr_q + 6'd1;
            rd_last_d = ((rd_ptr_q + 6'd1) == (len_q - 6'd1));
          end
        end
      end

      ST_DROP: begin
        if (bus.frame_start) begin
          state_d  = ST_LEN;
          len_d    = 6'd0;
          wr_ptr_d = 6'd0;
          sum_d    = 8'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      len_q         <= 6'd0;
      wr_ptr_q      <= 6'd0;
      rd_ptr_q      <= 6'd0;
      sum_q         <= 8'd0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 6'd0;
      rd_last_q     <= 1'b0;
      err_q         <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      sum_q         <= sum_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      rd_last_q     <= rd_last_d;
      err_q         <= err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      buffer_mem[wr_ptr_q[AW-1:0]] <= bus.data_in;
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.err         = err_q;
  assign bus.err_cnt     = err_cnt_q;
  // Readout is gated by state so the port reads zero outside a held frame
  // (including immediately on reset, since state_q clears asynchronously).
  assign bus.rd_data     = (state_q == ST_READY) ? buffer_mem[rd_ptr_q[AW-1:0]] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_assembler
//  Description : Self-checking bench for rx_frame_assembler. Frames are built
//                as byte lists (length, payload, checksum) and the expected
//                outcome is derived from the framing rules; the expected
//                error count is tracked as a saturating integer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_frame_assembler;

  localparam int MAX_LEN = 32;

  logic clk;
  logic rst_n;

  rx_frame_assembler_if bus_if ();

  rx_frame_assembler #(.MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #19 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_err = 0;          // expected err_cnt, saturating at 255
  logic [7:0] exp_q [$];    // payload expected from the held frame

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_err();
    if (exp_err < 255) exp_err++;
  endtask

  task automatic pulse_start();
    bus_if.frame_start = 1'b1;
    tick();
    bus_if.frame_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.new_data = 1'b1;
    bus_if.data_in  = b;
    tick();
    bus_if.new_data = 1'b0;
  endtask

  // Sends start, N, exp_q payload and its checksum (optionally corrupted).
  task automatic send_frame(input bit corrupt);
    int s = 0;
    pulse_start();
    send(8'(exp_q.size()));
    foreach (exp_q[i]) begin
      send(exp_q[i]);
      s += exp_q[i];
    end
    if (corrupt) send(8'(s % 256) ^ 8'($urandom_range(1, 255)));
    else         send(8'(s % 256));
  endtask

  task automatic fill_rand(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Pops the whole held frame and compares it with exp_q.
  task automatic read_frame(input string tag);
    int n = exp_q.size();
    chk({tag, "_valid"}, 32'(bus_if.frame_valid), 32'd1);
    chk({tag, "_len"}, 32'(bus_if.frame_len), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(exp_q[i]));
      chk({tag, "_last"}, 32'(bus_if.rd_last), 32'(i == n - 1));
      bus_if.rd_en = 1'b1;
      tick();
      bus_if.rd_en = 1'b0;
    end
    chk({tag, "_done"}, 32'(bus_if.frame_valid), 32'd0);
    chk({tag, "_errcnt"}, 32'(bus_if.err_cnt), 32'(exp_err));
  endtask

  initial begin
    bus_if.frame_start = 1'b0;
    bus_if.new_data    = 1'b0;
    bus_if.data_in     = 8'd0;
    bus_if.rd_en       = 1'b0;
    rst_n              = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(bus_if.frame_valid), 32'd0);
    chk("rst_len",   32'(bus_if.frame_len),   32'd0);
    chk("rst_last",  32'(bus_if.rd_last),     32'd0);
    chk("rst_err",   32'(bus_if.err),         32'd0);
    chk("rst_cnt",   32'(bus_if.err_cnt),     32'd0);
    chk("rst_data",  32'(bus_if.rd_data),     32'd0);
    rst_n = 1'b1;
    tick();

    // rd_en while idle must do nothing
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    chk("idle_rden", 32'(bus_if.frame_valid), 32'd0);

    // Good frame 03,11,22,33,66
    exp_q = '{8'h11, 8'h22, 8'h33};
    send_frame(1'b0);
    read_frame("good");

    // Bad checksum 02,AA,BB,00 then stray bytes ignored
    pulse_start();
    send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
    note_err();
    chk("badcs_err", 32'(bus_if.err), 32'd1);
    tick();
    chk("badcs_pulse", 32'(bus_if.err), 32'd0);
    chk("badcs_cnt", 32'(bus_if.err_cnt), 32'(exp_err));
    send(8'h01); send(8'h05); send(8'h05);
    bus_if.rd_en = 1'b1;
    tick();
    bus_if.rd_en = 1'b0;
    chk("drop_valid", 32'(bus_if.frame_valid), 32'd0);
    chk("drop_cnt", 32'(bus_if.err_cnt), 32'(exp_err));
    chk("drop_data", 32'(bus_if.rd_data), 32'd0);

    // Length bounds: 0 and MAX_LEN+1 rejected, MAX_LEN accepted
    pulse_start(); send(8'h00); note_err();
    chk("len0_err", 32'(bus_if.err), 32'd1);
    pulse_start();
    chk("drop_restart_noerr", 32'(bus_if.err), 32'd0);
    send(8'(MAX_LEN + 1)); note_err();
    chk("lenmax1_err", 32'(bus_if.err), 32'd1);
    tick();
    chk("len_cnt", 32'(bus_if.err_cnt), 32'(exp_err));
    fill_rand(MAX_LEN);
    send_frame(1'b0);
    read_frame("maxlen");

    // Overrun while a frame is held
    fill_rand(5);
    send_frame(1'b0);
    send(8'hDE); note_err();
    chk("ovr_err", 32'(bus_if.err), 32'd1);
    send(8'hAD); note_err();
    pulse_start();
    chk("ovr_cnt", 32'(bus_if.err_cnt), 32'(exp_err));
    read_frame("ovr");

    // Abort then restart
    pulse_start(); send(8'h01); send(8'h5A);
    pulse_start(); note_err();
    chk("abort_err", 32'(bus_if.err), 32'd1);
    send(8'h01); send(8'h7F); send(8'h7F);
    exp_q = '{8'h7F};
    read_frame("abort");

    // frame_start with new_data in the same cycle: byte is discarded
    pulse_start(); send(8'h02);
    bus_if.frame_start = 1'b1;
    bus_if.new_data    = 1'b1;
    bus_if.data_in     = 8'h55;
    tick();
    bus_if.frame_start = 1'b0;
    bus_if.new_data    = 1'b0;
    note_err();
    send(8'h01); send(8'h7F); send(8'h7F);
    read_frame("same_cycle");

    // Randomized frames against the rule model
    for (int k = 0; k < 10; k++) begin
      bit corrupt;
      corrupt = ($urandom_range(0, 2) == 0);
      fill_rand($urandom_range(1, MAX_LEN));
      send_frame(corrupt);
      if (corrupt) begin
        note_err();
        chk("rand_err", 32'(bus_if.err), 32'd1);
        chk("rand_nv", 32'(bus_if.frame_valid), 32'd0);
        tick();
        chk("rand_cnt", 32'(bus_if.err_cnt), 32'(exp_err));
      end else begin
        read_frame("rand");
      end
    end

    // Asynchronous reset mid-payload
    pulse_start(); send(8'h04); send(8'h10); send(8'h20);
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(bus_if.err_cnt), 32'd0);
    chk("arst_valid", 32'(bus_if.frame_valid), 32'd0);
    chk("arst_err", 32'(bus_if.err), 32'd0);
    chk("arst_data", 32'(bus_if.rd_data), 32'd0);
    exp_err = 0;
    tick();
    rst_n = 1'b1;
    tick();
    fill_rand(4);
    send_frame(1'b0);
    read_frame("post_rst");

    // err_cnt saturation
    for (int k = 0; k < 260; k++) begin
      pulse_start();
      send(8'h00);
      note_err();
    end
    tick();
    chk("sat_cnt", 32'(bus_if.err_cnt), 32'd255);
    chk("sat_model", 32'(bus_if.err_cnt), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
